// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// reorder_buffer : circular in-order-retire ROB with flush on exception/mispredict
// Revision 1.0
// ============================================================================
module reorder_buffer #(
  parameter int NUM_ROB_ENTS = 64,
  parameter int DISP_WIDTH   = 2,
  parameter int RETIRE_WIDTH = 4,
  parameter int NUM_FUS      = 4
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic [DISP_WIDTH-1:0]                                 alloc_valid,
  input  logic [DISP_WIDTH-1:0][45:0]                           alloc_entry,
  output logic                                                  alloc_ready,
  output logic [DISP_WIDTH-1:0][$clog2(NUM_ROB_ENTS)-1:0]       alloc_idx,
  input  logic [NUM_FUS-1:0]                                    cmpl_valid,
  input  logic [NUM_FUS-1:0][$clog2(NUM_ROB_ENTS)-1:0]          cmpl_idx,
  input  logic [NUM_FUS-1:0]                                    cmpl_exception,
  input  logic [NUM_FUS-1:0]                                    cmpl_br_mispred,
  output logic [RETIRE_WIDTH-1:0]                               retire_valid,
  output logic [RETIRE_WIDTH-1:0][45:0]                         retire_entry,
  output logic                                                  flush_valid,
  output logic [31:0]                                           flush_pc,
  output logic [$clog2(NUM_ROB_ENTS):0]                         count,
  output logic                                                  empty,
  output logic                                                  full
);

  localparam int IW = $clog2(NUM_ROB_ENTS);

  // Entry payload layout, MSB first: {dst_areg, dst_preg, exception, br_mispred, pc}
  typedef struct packed {
    logic [4:0]  dst_areg;
    logic [6:0]  dst_preg;
    logic        exception;
    logic        br_mispred;
    logic [31:0] pc;
  } rob_entry_t;

  rob_entry_t                          r_ent [NUM_ROB_ENTS];
  logic [NUM_ROB_ENTS-1:0]             r_valid;
  logic [NUM_ROB_ENTS-1:0]             r_done;
  logic [IW:0]                         r_head;
  logic [IW:0]                         r_tail;

  logic [IW:0]                         w_free;
  logic [IW:0]                         w_n_alloc;
  logic [IW:0]                         w_n_ret;
  logic                                w_stop;
  logic [RETIRE_WIDTH-1:0][IW-1:0]     w_ret_idx;
  logic [NUM_ROB_ENTS-1:0]             w_hit;
  logic [NUM_ROB_ENTS-1:0]             w_exc;
  logic [NUM_ROB_ENTS-1:0]             w_mis;

  assign count       = r_tail - r_head;
  assign empty       = (count == '0);
  assign full        = (count == (IW+1)'(NUM_ROB_ENTS));
  assign w_free      = (IW+1)'(NUM_ROB_ENTS) - count;
  assign alloc_ready = (w_free >= (IW+1)'(DISP_WIDTH));

  // Valid lanes are packed into consecutive slots starting at tail.
  always_comb begin
    w_n_alloc = '0;
    alloc_idx = '0;
    for (int i = 0; i < DISP_WIDTH; i++) begin
      alloc_idx[i] = r_tail[IW-1:0] + w_n_alloc[IW-1:0];
      if (alloc_valid[i]) w_n_alloc = w_n_alloc + (IW+1)'(1);
    end
  end

  // Retire stops at the first not-ready entry or right after a flagged one.
  always_comb begin
    w_n_ret      = '0;
    w_stop       = 1'b0;
    w_ret_idx    = '0;
    retire_valid = '0;
    retire_entry = '0;
    flush_valid  = 1'b0;
    flush_pc     = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      w_ret_idx[i]    = r_head[IW-1:0] + IW'(i);
      retire_entry[i] = r_ent[w_ret_idx[i]];
      if (!w_stop && r_valid[w_ret_idx[i]] && r_done[w_ret_idx[i]]) begin
        retire_valid[i] = 1'b1;
        w_n_ret         = w_n_ret + (IW+1)'(1);
        if (r_ent[w_ret_idx[i]].exception || r_ent[w_ret_idx[i]].br_mispred) begin
          w_stop      = 1'b1;
          flush_valid = 1'b1;
          flush_pc    = r_ent[w_ret_idx[i]].pc;
        end
      end else begin
        w_stop = 1'b1;
      end
    end
  end

  // Per-entry merge of all completion ports so same-index hits OR together.
  always_comb begin
    w_hit = '0;
    w_exc = '0;
    w_mis = '0;
    for (int k = 0; k < NUM_FUS; k++) begin
      if (cmpl_valid[k]) begin
        w_hit[cmpl_idx[k]] = 1'b1;
        w_exc[cmpl_idx[k]] = w_exc[cmpl_idx[k]] | cmpl_exception[k];
        w_mis[cmpl_idx[k]] = w_mis[cmpl_idx[k]] | cmpl_br_mispred[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
      for (int e = 0; e < NUM_ROB_ENTS; e++) r_ent[e] <= '0;
    end else if (flush_valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      for (int e = 0; e < NUM_ROB_ENTS; e++) begin
        if (w_hit[e] && r_valid[e]) begin
          r_done[e]           <= 1'b1;
          r_ent[e].exception  <= r_ent[e].exception  | w_exc[e];
          r_ent[e].br_mispred <= r_ent[e].br_mispred | w_mis[e];
        end
      end
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
        if (retire_valid[i]) r_valid[w_ret_idx[i]] <= 1'b0;
      end
      r_head <= r_head + w_n_ret;
      // Free slots never overlap retiring ones, so alloc writes cannot collide.
      if (alloc_ready) begin
        for (int i = 0; i < DISP_WIDTH; i++) begin
          if (alloc_valid[i]) begin
            r_ent[alloc_idx[i]]   <= alloc_entry[i];
            r_valid[alloc_idx[i]] <= 1'b1;
            r_done[alloc_idx[i]]  <= 1'b0;
          end
        end
        r_tail <= r_tail + w_n_alloc;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// tb_reorder_buffer : directed + random checks of reorder_buffer against a queue model
// Revision 1.0
// ============================================================================
module tb_reorder_buffer;

  typedef struct packed {
    logic [4:0]  dst_areg;
    logic [6:0]  dst_preg;
    logic        exception;
    logic        br_mispred;
    logic [31:0] pc;
  } entry_t;

  typedef struct {
    int     idx;
    entry_t ent;
    bit     done;
  } mrec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       alloc_valid;
  entry_t [1:0]     alloc_entry;
  logic             alloc_ready;
  logic [1:0][5:0]  alloc_idx;
  logic [3:0]       cmpl_valid;
  logic [3:0][5:0]  cmpl_idx;
  logic [3:0]       cmpl_exception;
  logic [3:0]       cmpl_br_mispred;
  logic [3:0]       retire_valid;
  entry_t [3:0]     retire_entry;
  logic             flush_valid;
  logic [31:0]      flush_pc;
  logic [6:0]       count;
  logic             empty;
  logic             full;

  int          checks = 0;
  int          errors = 0;
  mrec_t       q[$];
  int          mtail = 0;
  logic [5:0]  last_idx0, last_idx1;
  logic [3:0]  last_rv;
  logic        last_fv;
  logic [31:0] last_fpc;

  reorder_buffer #(
    .NUM_ROB_ENTS(64), .DISP_WIDTH(2), .RETIRE_WIDTH(4), .NUM_FUS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_entry(alloc_entry),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
    .cmpl_exception(cmpl_exception), .cmpl_br_mispred(cmpl_br_mispred),
    .retire_valid(retire_valid), .retire_entry(retire_entry),
    .flush_valid(flush_valid), .flush_pc(flush_pc),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    alloc_valid     = '0;
    alloc_entry     = '0;
    cmpl_valid      = '0;
    cmpl_idx        = '0;
    cmpl_exception  = '0;
    cmpl_br_mispred = '0;
  endtask

  function automatic entry_t mk(input logic [31:0] pc, input bit exc);
    entry_t e;
    e.dst_areg   = 5'($urandom);
    e.dst_preg   = 7'($urandom);
    e.exception  = exc;
    e.br_mispred = 1'b0;
    e.pc         = pc;
    return e;
  endfunction

  task automatic alloc2(input bit v0, input bit v1, input logic [31:0] pc0, input logic [31:0] pc1);
    alloc_valid    = {v1, v0};
    alloc_entry[0] = mk(pc0, 1'b0);
    alloc_entry[1] = mk(pc1, 1'b0);
  endtask

  // Complete up to four not-yet-done entries, oldest first.
  task automatic cmpl_some();
    int k = 0;
    cmpl_valid = '0;
    foreach (q[j]) begin
      if (!q[j].done && k < 4) begin
        cmpl_valid[k] = 1'b1;
        cmpl_idx[k]   = 6'(q[j].idx);
        k++;
      end
    end
  endtask

  task automatic cmpl_range(input int a, input int b, input int mis_pos);
    int k = 0;
    cmpl_valid = '0;
    for (int j = a; j <= b; j++) begin
      cmpl_valid[k]      = 1'b1;
      cmpl_idx[k]        = 6'(q[j].idx);
      cmpl_br_mispred[k] = (j == mis_pos);
      k++;
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic tick();
    int          n;
    int          below;
    bit          fl;
    bit          rdy;
    logic [31:0] fpc;
    @(negedge clk);
    #1;
    rdy = (64 - q.size()) >= 2;
    chk("count", 64'(count), 64'(q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("full", 64'(full), 64'(q.size() == 64));
    chk("alloc_ready", 64'(alloc_ready), 64'(rdy));
    below = 0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("alloc_idx%0d", i), 64'(alloc_idx[i]), 64'((mtail + below) % 64));
      if (alloc_valid[i]) below++;
    end
    n = 0; fl = 1'b0; fpc = '0;
    for (int i = 0; i < 4; i++) begin
      if (!fl && n == i && i < q.size() && q[i].done) begin
        n++;
        if (q[i].ent.exception || q[i].ent.br_mispred) begin
          fl  = 1'b1;
          fpc = q[i].ent.pc;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("retire_valid%0d", i), 64'(retire_valid[i]), 64'(i < n));
      if (i < n) chk($sformatf("retire_entry%0d", i), 64'(retire_entry[i]), 64'(q[i].ent));
    end
    chk("flush_valid", 64'(flush_valid), 64'(fl));
    chk("flush_pc", 64'(flush_pc), 64'(fpc));
    last_idx0 = alloc_idx[0];
    last_idx1 = alloc_idx[1];
    last_rv   = retire_valid;
    last_fv   = flush_valid;
    last_fpc  = flush_pc;
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
      mtail = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (cmpl_valid[k]) begin
          foreach (q[j]) begin
            if (q[j].idx == int'(cmpl_idx[k])) begin
              q[j].done = 1'b1;
              q[j].ent.exception  = q[j].ent.exception  | cmpl_exception[k];
              q[j].ent.br_mispred = q[j].ent.br_mispred | cmpl_br_mispred[k];
            end
          end
        end
      end
      repeat (n) void'(q.pop_front());
      if (rdy) begin
        for (int i = 0; i < 2; i++) begin
          if (alloc_valid[i]) begin
            q.push_back('{mtail, alloc_entry[i], 1'b0});
            mtail = (mtail + 1) % 64;
          end
        end
      end
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && q.size() > 0; t++) begin
      clr();
      cmpl_some();
      tick();
    end
    clr();
    chk("drain_done", 64'(q.size()), 64'd0);
  endtask

  initial begin
    clr();
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_retire_valid", 64'(retire_valid), 64'd0);
    chk("rst_flush", 64'({flush_valid, flush_pc}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two-lane allocation
    alloc2(1, 1, 32'h100, 32'h104);
    tick();
    chk("a_idx0", 64'(last_idx0), 64'd0);
    chk("a_idx1", 64'(last_idx1), 64'd1);
    chk("a_count", 64'(count), 64'd2);
    clr();

    // Out-of-order completion, in-order retire
    cmpl_valid[0] = 1'b1; cmpl_idx[0] = 6'd1;
    tick();
    clr();
    tick();
    cmpl_valid[0] = 1'b1; cmpl_idx[0] = 6'd0;
    tick();
    clr();
    tick();
    chk("ooo_retire", 64'(last_rv), 64'h3);
    chk("ooo_count", 64'(count), 64'd0);

    // Fill to full, allocation dropped while full
    for (int c = 0; c < 32; c++) begin
      alloc2(1, 1, 32'h1000 + 32'(c * 8), 32'h1004 + 32'(c * 8));
      tick();
    end
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_ready", 64'(alloc_ready), 64'd0);
    alloc2(1, 1, 32'hdead0, 32'hdead4);
    tick();
    tick();
    chk("fill_count", 64'(count), 64'd64);
    drain();

    // Six done entries retire 4 then 2
    for (int c = 0; c < 3; c++) begin
      alloc2(1, 1, 32'h3000 + 32'(c * 8), 32'h3004 + 32'(c * 8));
      tick();
    end
    clr();
    cmpl_range(2, 5, -1);
    tick();
    clr();
    cmpl_range(0, 1, -1);
    tick();
    clr();
    tick();
    chk("six_first", 64'(last_rv), 64'hf);
    tick();
    chk("six_second", 64'(last_rv), 64'h3);
    chk("six_count", 64'(count), 64'd0);

    // Asynchronous reset with retire-ready entries in flight
    alloc2(1, 1, 32'h4000, 32'h4004);
    tick();
    clr();
    cmpl_range(0, 1, -1);
    tick();
    clr();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_retire", 64'(retire_valid), 64'd0);
    chk("mrst_flush", 64'(flush_valid), 64'd0);
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_ready", 64'(alloc_ready), 64'd1);
    q.delete();
    mtail = 0;
    @(posedge clk);
    #1;
    chk("mrst_empty", 64'(empty), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Mispredicted branch in slot 1 flushes
    alloc2(1, 1, 32'h200, 32'h208);
    tick();
    alloc2(1, 1, 32'h210, 32'h218);
    tick();
    clr();
    cmpl_range(0, 3, 1);
    tick();
    clr();
    tick();
    chk("br_retire", 64'(last_rv), 64'h3);
    chk("br_flush", 64'(last_fv), 64'd1);
    chk("br_flush_pc", 64'(last_fpc), 64'h208);
    chk("br_empty", 64'(empty), 64'd1);
    chk("br_tail", 64'(alloc_idx[0]), 64'd0);

    // Allocation across the index wrap
    for (int c = 0; c < 31; c++) begin
      alloc2(1, 1, 32'h5000 + 32'(c * 8), 32'h5004 + 32'(c * 8));
      tick();
    end
    drain();
    alloc2(1, 1, 32'h6000, 32'h6004);
    tick();
    chk("wrap_idx0", 64'(last_idx0), 64'd62);
    chk("wrap_idx1", 64'(last_idx1), 64'd63);
    alloc2(1, 1, 32'h6008, 32'h600c);
    tick();
    chk("wrap_idx2", 64'(last_idx0), 64'd0);
    chk("wrap_idx3", 64'(last_idx1), 64'd1);
    drain();

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      clr();
      alloc_valid    = 2'($urandom);
      alloc_entry[0] = mk($urandom, ($urandom % 64) == 0);
      alloc_entry[1] = mk($urandom, ($urandom % 64) == 0);
      for (int k = 0; k < 4; k++) begin
        if (($urandom % 10) < 7) begin
          cmpl_valid[k] = 1'b1;
          if (q.size() > 0) cmpl_idx[k] = 6'(q[$urandom % q.size()].idx);
          else              cmpl_idx[k] = 6'($urandom);
          cmpl_exception[k]  = ($urandom % 40) == 0;
          cmpl_br_mispred[k] = ($urandom % 40) == 0;
        end
      end
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter NUM_ROB_ENTS, default 64, number of ROB entries (power of two).
REQ-002 SHALL have parameter DISP_WIDTH, default 2, allocation lanes per cycle.
REQ-003 SHALL have parameter RETIRE_WIDTH, default 4, retire lanes per cycle.
REQ-004 SHALL have parameter NUM_FUS, default 4, completion ports.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port alloc_valid  input  DISP_WIDTH  per-lane allocation request from dispatch.
REQ-008 SHALL have port alloc_entry  input  DISP_WIDTH x ROB_Entry  per-lane entry payload (dst_areg, dst_preg, exception, br_mispred, pc).
REQ-009 SHALL have port alloc_ready  output  1  at least DISP_WIDTH entries free.
REQ-010 SHALL have port alloc_idx  output  DISP_WIDTH x log2(NUM_ROB_ENTS)  ROB index granted to each lane.
REQ-011 SHALL have port cmpl_valid  input  NUM_FUS  per-FU completion strobe.
REQ-012 SHALL have port cmpl_idx  input  NUM_FUS x log2(NUM_ROB_ENTS)  ROB index being completed.
REQ-013 SHALL have port cmpl_exception  input  NUM_FUS  completion raised exception.
REQ-014 SHALL have port cmpl_br_mispred  input  NUM_FUS  completion is a mispredicted branch.
REQ-015 SHALL have port retire_valid  output  RETIRE_WIDTH  per-lane retire strobe, oldest in lane 0.
REQ-016 SHALL have port retire_entry  output  RETIRE_WIDTH x ROB_Entry  retired entry contents with merged flags.
REQ-017 SHALL have port flush_valid  output  1  one-cycle pipeline flush pulse.
REQ-018 SHALL have port flush_pc  output  32  pc of the entry causing the flush.
REQ-019 SHALL have ports count  output  log2(NUM_ROB_ENTS)+1, empty  output  1, full  output  1  occupancy status.

Function
REQ-020 SHALL be a circular buffer with head/tail pointers carrying an extra wrap bit; count = tail - head; empty when count=0; full when count=NUM_ROB_ENTS.
REQ-021 SHALL assert alloc_ready when NUM_ROB_ENTS - count >= DISP_WIDTH, from registered state only.
REQ-022 SHALL, when alloc_ready=1, write valid lanes into consecutive slots starting at tail in lane order (invalid lanes compacted out), set valid=1, done=0, advance tail by number of valid lanes.
REQ-023 SHALL drive alloc_idx[i] combinationally as tail + (number of valid lanes below i); alloc_valid with alloc_ready=0 is dropped without state change.
REQ-024 SHALL, on cmpl_valid[k] to a valid entry, set done=1 and OR cmpl_exception/cmpl_br_mispred into the entry flags at the clock edge; completion to an invalid entry is ignored.
REQ-025 SHALL OR flags when several ports complete the same index in one cycle.
REQ-026 SHALL derive retire outputs combinationally from registered state only; a completion is retire-eligible no earlier than the cycle after cmpl_valid.
REQ-027 SHALL retire in lane i the entry head+i iff entries head..head+i are all valid and done, none of head..head+i-1 has exception or br_mispred, and i < RETIRE_WIDTH.
REQ-028 SHALL, when the retiring entry with the highest lane index has exception or br_mispred set, assert flush_valid with flush_pc = that entry's pc in the same cycle.
REQ-029 SHALL advance head by the number of retired lanes at the clock edge.
REQ-030 SHALL, on flush, at that clock edge clear every valid bit, set head=tail=0, and discard that cycle's allocation and completions.
REQ-031 SHALL handle allocation and retire in the same cycle, including when full (alloc_ready still computed from pre-retire count).
REQ-032 SHALL wrap all indices modulo NUM_ROB_ENTS with wrap bit toggle at the boundary.

Reset
REQ-033 SHALL, while rst_n=0, immediately force head=tail=0, all valid/done/flag bits 0, retire_valid=0, flush_valid=0, flush_pc=0, count=0, empty=1, full=0, alloc_ready=1.
REQ-034 SHALL, on reset mid-operation, discard all in-flight entries with no retire or flush pulse emitted.

Verification
REQ-035 Reset, alloc 2 lanes (pc 0x100,0x104) -> alloc_idx 0,1; count=2 next cycle; no retire.
REQ-036 Complete idx 1 then idx 0 on later cycle -> both retire together in lanes 0,1 the cycle after idx 0 completes; count=0.
REQ-037 Fill 64 entries (32 cycles of 2) -> full=1, alloc_ready=0; further alloc_valid ignored, count stays 64.
REQ-038 6 done entries at head -> cycle 1 retires 4, cycle 2 retires 2; head advances 4 then 2.
REQ-039 Entries 0..3 done, entry 1 br_mispred pc 0x208 -> retire lanes 0,1 only, flush_valid=1, flush_pc=0x208; next cycle empty=1, tail=0.
REQ-040 Head at 62, alloc 4 across wrap -> indices 62,63,0,1; retire in order across boundary, count correct throughout.
